// File: rtl/id_operand_unit_if.sv
// ---------------------------------------------------------------------------
// id_operand_unit_if
// Bundle between the decode stage and id_operand_unit.
//   master : decode-side driver (regfile data, forwarding buses, issuing
//            instruction attributes, pipeline control); receives the
//            resolved operands, stallreq and div_busy.
//   slave  : id_operand_unit.
// Signals:
//   flush, pipe_adv, id_valid         pipeline control
//   raddr1/2, use1/2, rf_rdata1/2     register reads
//   fwd_we, fwd_waddr, fwd_wdata      packed forwarding sources (0 = youngest)
//   iss_we, iss_waddr, iss_is_load,
//   iss_is_div, iss_hilo              attributes of the instruction in ID
//   rdata1/2, stallreq, div_busy      results
// ---------------------------------------------------------------------------
interface id_operand_unit_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 3
);
    logic                      flush;
    logic                      pipe_adv;
    logic                      id_valid;
    logic [4:0]                raddr1;
    logic [4:0]                raddr2;
    logic                      use1;
    logic                      use2;
    logic [DATA_W-1:0]         rf_rdata1;
    logic [DATA_W-1:0]         rf_rdata2;
    logic [NUM_FWD-1:0]        fwd_we;
    logic [5*NUM_FWD-1:0]      fwd_waddr;
    logic [DATA_W*NUM_FWD-1:0] fwd_wdata;
    logic                      iss_we;
    logic [4:0]                iss_waddr;
    logic                      iss_is_load;
    logic                      iss_is_div;
    logic                      iss_hilo;
    logic [DATA_W-1:0]         rdata1;
    logic [DATA_W-1:0]         rdata2;
    logic                      stallreq;
    logic                      div_busy;

    modport master (
        output flush, pipe_adv, id_valid, raddr1, raddr2, use1, use2,
               rf_rdata1, rf_rdata2, fwd_we, fwd_waddr, fwd_wdata,
               iss_we, iss_waddr, iss_is_load, iss_is_div, iss_hilo,
        input  rdata1, rdata2, stallreq, div_busy
    );

    modport slave (
        input  flush, pipe_adv, id_valid, raddr1, raddr2, use1, use2,
               rf_rdata1, rf_rdata2, fwd_we, fwd_waddr, fwd_wdata,
               iss_we, iss_waddr, iss_is_load, iss_is_div, iss_hilo,
        output rdata1, rdata2, stallreq, div_busy
    );
endinterface

// File: rtl/id_operand_unit.sv
// ---------------------------------------------------------------------------
// id_operand_unit
// Decode-stage operand resolution and hazard detection.
//   - Merges regfile read data with NUM_FWD forwarding sources (index 0 is
//     the youngest and wins).
//   - Tracks in-flight loads in a LOAD_LAT-deep scoreboard and raises a
//     load-use stall while a consumer's source is still pending.
//   - Counts down an in-flight divide; HI/LO accesses stall until it ends.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  id_operand_unit_if.slave (see interface for the signal list)
// ---------------------------------------------------------------------------
module id_operand_unit #(
    parameter int DATA_W   = 32,
    parameter int NUM_FWD  = 3,
    parameter int LOAD_LAT = 2,
    parameter int DIV_LAT  = 32
) (
    input logic              clk,
    input logic              rst,
    id_operand_unit_if.slave bus
);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT);

    logic                issue;
    logic                load_hz;
    logic                div_hz;
    logic                stall;
    logic [LOAD_LAT-1:0] sb_valid;
    logic [4:0]          sb_waddr [LOAD_LAT];
    logic [5:0]          div_cnt;
    logic [DATA_W-1:0]   fwd1;
    logic [DATA_W-1:0]   fwd2;
    logic                hit1;
    logic                hit2;

    // Priority search: first hit from index 0 upward is kept.
    always_comb begin
        fwd1 = '0;
        fwd2 = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!hit1 && bus.fwd_we[i] && (bus.fwd_waddr[5*i +: 5] == bus.raddr1)) begin
                fwd1 = bus.fwd_wdata[DATA_W*i +: DATA_W];
                hit1 = 1'b1;
            end
            if (!hit2 && bus.fwd_we[i] && (bus.fwd_waddr[5*i +: 5] == bus.raddr2)) begin
                fwd2 = bus.fwd_wdata[DATA_W*i +: DATA_W];
                hit2 = 1'b1;
            end
        end
    end

    always_comb begin
        bus.rdata1 = '0;
        bus.rdata2 = '0;
        if (bus.id_valid && (bus.raddr1 != 5'd0))
            bus.rdata1 = hit1 ? fwd1 : bus.rf_rdata1;
        if (bus.id_valid && (bus.raddr2 != 5'd0))
            bus.rdata2 = hit2 ? fwd2 : bus.rf_rdata2;
    end

    // Forwarding never masks a pending load: the scoreboard alone decides.
    always_comb begin
        load_hz = 1'b0;
        for (int unsigned i = 0; i < LOAD_LAT; i++) begin
            if (sb_valid[i] &&
                ((bus.use1 && (bus.raddr1 == sb_waddr[i]) && (bus.raddr1 != 5'd0)) ||
                 (bus.use2 && (bus.raddr2 == sb_waddr[i]) && (bus.raddr2 != 5'd0))))
                load_hz = 1'b1;
        end
        load_hz = load_hz & bus.id_valid;
    end

    always_comb begin
        div_hz       = bus.id_valid & bus.iss_hilo & (div_cnt != 6'd0);
        stall        = (load_hz | div_hz) & ~rst;
        issue        = bus.id_valid & ~stall & bus.pipe_adv;
        bus.stallreq = stall;
        bus.div_busy = (div_cnt != 6'd0);
    end

    // Destination addresses are left unreset; valid bits gate them.
    // Entry 0 receives a bubble whenever ID does not issue.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            sb_valid <= '0;
            div_cnt  <= '0;
        end else begin
            if (bus.pipe_adv) begin
                for (int unsigned i = 1; i < LOAD_LAT; i++) begin
                    sb_valid[i] <= sb_valid[i-1];
                    sb_waddr[i] <= sb_waddr[i-1];
                end
                sb_valid[0] <= issue & bus.iss_is_load & bus.iss_we & (bus.iss_waddr != 5'd0);
                sb_waddr[0] <= bus.iss_waddr;
            end
            if (issue && bus.iss_is_div)
                div_cnt <= DIV_LOAD;
            else if (div_cnt != 6'd0)
                div_cnt <= div_cnt - 6'd1;
        end
    end
endmodule

// File: tb/tb_id_operand_unit.sv
module tb_id_operand_unit;
    localparam int DATA_W   = 32;
    localparam int NUM_FWD  = 3;
    localparam int LOAD_LAT = 2;
    localparam int DIV_LAT  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_operand_unit_if #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) bus ();

    id_operand_unit #(
        .DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .LOAD_LAT(LOAD_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Forwarding sources as plain arrays; packed onto the bus by drive_fwd.
    logic              src_we   [NUM_FWD];
    logic [4:0]        src_addr [NUM_FWD];
    logic [DATA_W-1:0] src_data [NUM_FWD];

    // Reference model: list of pending loads with their age in advances,
    // and remaining divide cycles.
    int         ld_age  [$];
    logic [4:0] ld_addr [$];
    int         div_rem = 0;

    function automatic logic [DATA_W-1:0] exp_rdata(input logic [4:0] ra, input logic [DATA_W-1:0] rf);
        if (!bus.id_valid || ra == 5'd0) return '0;
        for (int i = 0; i < NUM_FWD; i++)
            if (src_we[i] && src_addr[i] == ra) return src_data[i];
        return rf;
    endfunction

    function automatic logic exp_stall();
        logic hz;
        hz = 1'b0;
        foreach (ld_addr[k]) begin
            if (bus.use1 && bus.raddr1 != 5'd0 && bus.raddr1 == ld_addr[k]) hz = 1'b1;
            if (bus.use2 && bus.raddr2 != 5'd0 && bus.raddr2 == ld_addr[k]) hz = 1'b1;
        end
        if (bus.iss_hilo && div_rem > 0) hz = 1'b1;
        return hz && bus.id_valid && !rst;
    endfunction

    task automatic drive_fwd();
        for (int i = 0; i < NUM_FWD; i++) begin
            bus.fwd_we[i]                = src_we[i];
            bus.fwd_waddr[5*i +: 5]      = src_addr[i];
            bus.fwd_wdata[DATA_W*i +: DATA_W] = src_data[i];
        end
    endtask

    task automatic clear_inputs();
        bus.flush = 0; bus.pipe_adv = 0; bus.id_valid = 0;
        bus.raddr1 = 0; bus.raddr2 = 0; bus.use1 = 0; bus.use2 = 0;
        bus.rf_rdata1 = 0; bus.rf_rdata2 = 0;
        bus.iss_we = 0; bus.iss_waddr = 0; bus.iss_is_load = 0;
        bus.iss_is_div = 0; bus.iss_hilo = 0;
        for (int i = 0; i < NUM_FWD; i++) begin
            src_we[i] = 0; src_addr[i] = 0; src_data[i] = 0;
        end
        drive_fwd();
    endtask

    task automatic set_instr(input logic v, input logic [4:0] r1, input logic u1,
                             input logic [4:0] r2, input logic u2, input logic we,
                             input logic [4:0] wa, input logic ld, input logic dv,
                             input logic hl);
        bus.id_valid = v; bus.raddr1 = r1; bus.use1 = u1; bus.raddr2 = r2; bus.use2 = u2;
        bus.iss_we = we; bus.iss_waddr = wa; bus.iss_is_load = ld;
        bus.iss_is_div = dv; bus.iss_hilo = hl;
    endtask

    task automatic model_clock();
        logic stall, issue;
        stall = exp_stall();
        if (rst || bus.flush) begin
            ld_age.delete(); ld_addr.delete(); div_rem = 0;
        end else begin
            issue = bus.id_valid && !stall && bus.pipe_adv;
            if (bus.pipe_adv) begin
                foreach (ld_age[k]) ld_age[k]++;
                while (ld_age.size() > 0 && ld_age[0] >= LOAD_LAT) begin
                    void'(ld_age.pop_front());
                    void'(ld_addr.pop_front());
                end
                if (issue && bus.iss_is_load && bus.iss_we && bus.iss_waddr != 5'd0) begin
                    ld_age.push_back(0);
                    ld_addr.push_back(bus.iss_waddr);
                end
            end
            if (issue && bus.iss_is_div) div_rem = DIV_LAT;
            else if (div_rem > 0) div_rem--;
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        clear_inputs();
        bus.pipe_adv = 1;
        for (int i = 0; i < DIV_LAT + LOAD_LAT + 2; i++) tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick(); tick();
        #1;
        checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL rst_stallreq got %0b expected 0", bus.stallreq); end
        checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL rst_div_busy got %0b expected 0", bus.div_busy); end
        checks++; if (bus.rdata1 !== '0) begin errors++; $display("FAIL rst_rdata1 got %0h expected 0", bus.rdata1); end
        checks++; if (bus.rdata2 !== '0) begin errors++; $display("FAIL rst_rdata2 got %0h expected 0", bus.rdata2); end
        rst = 0;
        tick();
    endtask

    task automatic test_forward();
        clear_inputs();
        set_instr(1, 5, 1, 6, 1, 0, 0, 0, 0, 0);
        bus.rf_rdata1 = 32'd99; bus.rf_rdata2 = 32'h1234;
        for (int i = 0; i < NUM_FWD; i++) begin
            src_we[i] = 1; src_addr[i] = 5; src_data[i] = 32'(10 * (i + 1));
        end
        drive_fwd(); #1;
        checks++; if (bus.rdata1 !== 32'd10) begin errors++; $display("FAIL fwd_all got %0d expected 10", bus.rdata1); end
        checks++; if (bus.rdata2 !== 32'h1234) begin errors++; $display("FAIL fwd_rf2 got %0h expected 1234", bus.rdata2); end
        src_we[0] = 0; drive_fwd(); #1;
        checks++; if (bus.rdata1 !== 32'd20) begin errors++; $display("FAIL fwd_110 got %0d expected 20", bus.rdata1); end
        src_we[1] = 0; drive_fwd(); #1;
        checks++; if (bus.rdata1 !== 32'd30) begin errors++; $display("FAIL fwd_100 got %0d expected 30", bus.rdata1); end
        src_we[2] = 0; drive_fwd(); #1;
        checks++; if (bus.rdata1 !== 32'd99) begin errors++; $display("FAIL fwd_none got %0d expected 99", bus.rdata1); end
        src_we[0] = 1; src_addr[0] = 0; drive_fwd(); bus.raddr1 = 0; #1;
        checks++; if (bus.rdata1 !== 32'd0) begin errors++; $display("FAIL fwd_r0 got %0d expected 0", bus.rdata1); end
        bus.raddr1 = 5; bus.id_valid = 0; #1;
        checks++; if (bus.rdata1 !== 32'd0) begin errors++; $display("FAIL fwd_invalid got %0d expected 0", bus.rdata1); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        drain();
        bus.pipe_adv = 1;
        set_instr(1, 0, 0, 0, 0, 1, 8, 1, 0, 0); #1;
        checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL lu_issue got %0b expected 0", bus.stallreq); end
        tick();
        set_instr(1, 8, 1, 3, 1, 1, 10, 0, 0, 0);
        src_we[0] = 1; src_addr[0] = 8; src_data[0] = 32'hABCD; drive_fwd(); #1;
        checks++; if (bus.stallreq !== 1'b1) begin errors++; $display("FAIL lu_stall_c1 got %0b expected 1", bus.stallreq); end
        tick(); #1;
        checks++; if (bus.stallreq !== 1'b1) begin errors++; $display("FAIL lu_stall_c2 got %0b expected 1", bus.stallreq); end
        tick(); #1;
        checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL lu_stall_c3 got %0b expected 0", bus.stallreq); end
        clear_inputs(); bus.pipe_adv = 1;
        set_instr(1, 0, 0, 0, 0, 1, 8, 1, 0, 0); tick();
        set_instr(1, 9, 1, 0, 0, 1, 10, 0, 0, 0); #1;
        checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL lu_other_reg got %0b expected 0", bus.stallreq); end
        tick();
    endtask

    task automatic test_load_freeze();
        int stalls;
        drain();
        bus.pipe_adv = 1;
        set_instr(1, 0, 0, 0, 0, 1, 8, 1, 0, 0); tick();
        set_instr(1, 0, 0, 8, 1, 1, 11, 0, 0, 0);
        stalls = 0;
        for (int c = 0; c < 20; c++) begin
            bus.pipe_adv = (c >= 3); #1;
            checks++; if (bus.stallreq !== exp_stall()) begin errors++; $display("FAIL lf_cycle%0d got %0b expected %0b", c, bus.stallreq, exp_stall()); end
            if (!bus.stallreq) break;
            stalls++;
            tick();
        end
        checks++; if (stalls != 5) begin errors++; $display("FAIL lf_total got %0d expected 5", stalls); end
        tick();
    endtask

    task automatic test_divide();
        drain();
        bus.pipe_adv = 1;
        set_instr(1, 4, 1, 5, 1, 0, 0, 0, 1, 1); #1;
        checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL div_pre got %0b expected 0", bus.div_busy); end
        tick();
        for (int c = 0; c < DIV_LAT; c++) begin
            if (c == 10) set_instr(1, 3, 1, 4, 1, 1, 2, 0, 0, 0);
            else         set_instr(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
            #1;
            checks++; if (bus.div_busy !== 1'b1) begin errors++; $display("FAIL div_busy_c%0d got %0b expected 1", c, bus.div_busy); end
            checks++; if (bus.stallreq !== (c != 10)) begin errors++; $display("FAIL div_stall_c%0d got %0b expected %0b", c, bus.stallreq, c != 10); end
            tick();
        end
        set_instr(1, 0, 0, 0, 0, 1, 2, 0, 0, 1); #1;
        checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL div_done_busy got %0b expected 0", bus.div_busy); end
        checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL div_done_stall got %0b expected 0", bus.stallreq); end
        tick();
    endtask

    task automatic test_flush();
        drain();
        bus.pipe_adv = 1;
        set_instr(1, 0, 0, 0, 0, 1, 8, 1, 0, 0); tick();
        set_instr(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
        clear_inputs(); bus.flush = 1; #1;
        checks++; if (bus.div_busy !== 1'b1) begin errors++; $display("FAIL fl_busy_before got %0b expected 1", bus.div_busy); end
        tick();
        bus.flush = 0;
        set_instr(1, 8, 1, 0, 0, 1, 3, 0, 0, 1); #1;
        checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL fl_busy_after got %0b expected 0", bus.div_busy); end
        checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL fl_stall_after got %0b expected 0", bus.stallreq); end
        clear_inputs();
        bus.pipe_adv = 1; bus.flush = 1;
        set_instr(1, 0, 0, 0, 0, 1, 8, 1, 0, 0); tick();
        bus.flush = 0;
        set_instr(1, 8, 1, 0, 0, 1, 3, 0, 0, 0); #1;
        checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL fl_same_cycle got %0b expected 0", bus.stallreq); end
        tick();
    endtask

    task automatic test_reset_mid();
        drain();
        bus.pipe_adv = 1;
        set_instr(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
        clear_inputs(); bus.pipe_adv = 1;
        for (int i = 0; i < 13; i++) tick();
        set_instr(1, 0, 0, 0, 0, 1, 8, 1, 0, 0); tick();
        set_instr(1, 0, 0, 0, 0, 1, 9, 1, 0, 0); tick();
        set_instr(1, 8, 1, 9, 1, 1, 3, 0, 0, 1); bus.pipe_adv = 0; #1;
        checks++; if (bus.stallreq !== 1'b1) begin errors++; $display("FAIL rm_stall_before got %0b expected 1", bus.stallreq); end
        checks++; if (bus.div_busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before got %0b expected 1", bus.div_busy); end
        rst = 1; #1;
        checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL rm_stall_in_rst got %0b expected 0", bus.stallreq); end
        tick();
        rst = 0; #1;
        checks++; if (bus.div_busy !== 1'b0) begin errors++; $display("FAIL rm_busy_after got %0b expected 0", bus.div_busy); end
        checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL rm_stall_after got %0b expected 0", bus.stallreq); end
        tick();
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] e1, e2;
        logic es, eb;
        drain();
        for (int c = 0; c < 600; c++) begin
            bus.id_valid    = ($urandom_range(0, 9) != 0);
            bus.raddr1      = 5'($urandom_range(0, 7));
            bus.raddr2      = 5'($urandom_range(0, 7));
            bus.use1        = 1'($urandom);
            bus.use2        = 1'($urandom);
            bus.rf_rdata1   = $urandom;
            bus.rf_rdata2   = $urandom;
            bus.iss_we      = 1'($urandom);
            bus.iss_waddr   = 5'($urandom_range(0, 7));
            bus.iss_is_load = ($urandom_range(0, 2) == 0);
            bus.iss_is_div  = ($urandom_range(0, 59) == 0);
            bus.iss_hilo    = bus.iss_is_div || ($urandom_range(0, 5) == 0);
            bus.pipe_adv    = ($urandom_range(0, 3) != 0);
            bus.flush       = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < NUM_FWD; i++) begin
                src_we[i] = 1'($urandom); src_addr[i] = 5'($urandom_range(0, 7)); src_data[i] = $urandom;
            end
            drive_fwd(); #1;
            e1 = exp_rdata(bus.raddr1, bus.rf_rdata1);
            e2 = exp_rdata(bus.raddr2, bus.rf_rdata2);
            es = exp_stall();
            eb = (div_rem > 0);
            checks++; if (bus.rdata1 !== e1) begin errors++; $display("FAIL rnd_rdata1 c%0d got %0h expected %0h", c, bus.rdata1, e1); end
            checks++; if (bus.rdata2 !== e2) begin errors++; $display("FAIL rnd_rdata2 c%0d got %0h expected %0h", c, bus.rdata2, e2); end
            checks++; if (bus.stallreq !== es) begin errors++; $display("FAIL rnd_stall c%0d got %0b expected %0b", c, bus.stallreq, es); end
            checks++; if (bus.div_busy !== eb) begin errors++; $display("FAIL rnd_busy c%0d got %0b expected %0b", c, bus.div_busy, eb); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_load_freeze();
        test_divide();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_operand_unit.md
Name: id_operand_unit

Overview:
Parametrised operand-resolution and hazard unit for the decode stage. It merges register-file read data with a configurable number of forwarding sources, and tracks in-flight loads in a LOAD_LAT-deep scoreboard to generate load-use stalls of any latency. It also counts an in-flight multi-cycle divide so that HI/LO accesses stall until the divide completes. It sits between the regfile read ports and the ID/EX bus, and drives stallreq to the stall controller.

Parameters:
DATA_W, 32, operand width
NUM_FWD, 3, number of forwarding sources; index 0 is the youngest (EX) and has the highest priority
LOAD_LAT, 2, number of pipeline advances after EX before load data is forwardable (range 1..4)
DIV_LAT, 32, cycles a divide occupies HI/LO (range 1..63)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  clears the scoreboard and the divide counter
pipe_adv  in  1  stages after ID advance this cycle
id_valid  in  1  ID holds a real instruction (ce)
raddr1  in  5  rs address
raddr2  in  5  rt address
use1  in  1  instruction reads rs
use2  in  1  instruction reads rt
rf_rdata1  in  DATA_W  regfile port 1 data
rf_rdata2  in  DATA_W  regfile port 2 data
fwd_we  in  NUM_FWD  per-source write enable
fwd_waddr  in  5*NUM_FWD  packed destinations; source i occupies [5i+4:5i]
fwd_wdata  in  DATA_W*NUM_FWD  packed data
iss_we  in  1  issuing instruction writes a GPR
iss_waddr  in  5  its destination
iss_is_load  in  1  issuing instruction is a load
iss_is_div  in  1  issuing instruction is div/divu
iss_hilo  in  1  issuing instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
rdata1  out  DATA_W  resolved rs operand
rdata2  out  DATA_W  resolved rt operand
stallreq  out  1  ID must hold
div_busy  out  1  divide in flight

Behaviour:
- issue = id_valid & ~stallreq & pipe_adv.
- Operand resolution is combinational:
  - If id_valid=0, rdataN = 0.
  - If raddrN = 0, rdataN = 0. r0 is never forwarded and never pending.
  - Otherwise rdataN is taken from the lowest-index source i with fwd_we[i] and a matching waddr; if none matches, rdataN = rf_rdataN.
- Load scoreboard: LOAD_LAT entries of {valid, waddr}. Entry 0 is the instruction now in EX.
  - On pipe_adv=1: entries shift up and the last entry is discarded.
  - Entry 0 is loaded with {issue & iss_is_load & iss_we & (iss_waddr!=0), iss_waddr}. A bubble (valid=0) is inserted when ID stalls.
  - On pipe_adv=0: entries hold.
- load_hz = id_valid & OR over entries of (valid & ((use1 & raddr1==waddr & raddr1!=0) | (use2 & raddr2==waddr & raddr2!=0))).
- Divide counter: 6-bit count.
  - Loaded with DIV_LAT when issue & iss_is_div.
  - Otherwise decrements every clock while nonzero; it does not depend on pipe_adv.
  - div_busy = (count != 0).
- div_hz = id_valid & iss_hilo & div_busy.
- stallreq = (load_hz | div_hz) & ~rst.
- Reset or flush, registered:
  - All scoreboard entries become invalid and count becomes 0, taking effect on the next cycle.
  - flush has priority over a same-cycle issue: nothing is inserted and the counter is not loaded.
- Reset values: stallreq=0, div_busy=0, rdata1/rdata2 = 0 (id_valid is 0 under reset).
- Simultaneous events:
  - Load issue while an older matching entry shifts out: the new entry is inserted and the old one retires in the same cycle.
  - A forwarding match does not cancel load_hz; the scoreboard wins.
  - A div issuing while count=1 reloads to DIV_LAT.

Test Plan:
1. Forward priority: fwd_we=3'b111, all waddr=5, wdata={30,20,10}, raddr1=5, id_valid=1 -> rdata1=10. With fwd_we=3'b110 -> rdata1=20. With raddr1=0 -> rdata1=0.
2. Load-use, LOAD_LAT=2: issue lw to r8, then hold pipe_adv=1 with a consumer of r8 in ID -> stallreq=1 for exactly 2 cycles, then 0. A consumer of r9 does not stall.
3. pipe_adv=0 for 3 cycles after the load issues -> the entry is frozen and the r8 consumer stalls 3+2 cycles in total.
4. Divide, DIV_LAT=32: issue div, then mflo in ID -> div_busy=1 and stallreq=1 for 32 cycles, 0 on cycle 33. An addu in ID during this time does not stall.
5. flush one cycle after a load and a div issue -> next cycle div_busy=0, the scoreboard is empty and stallreq=0. A flush in the same cycle as a load issue inserts nothing.
6. Reset asserted mid-divide (count=17) and with 2 valid entries -> after one clock count=0, entries invalid, stallreq=0.
